uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Byte buffer and sequencer sitting directly upstream of the UART transmitter. Accepts bytes from a producer at clock rate into a circular FIFO and issues them one at a time to the transmitter via a single-cycle `tx_start` pulse with stable `data_out`. It then waits for the transmitter's `tx_done_tick` before releasing the next byte. Provides full/empty/count status and a sticky overflow flag so bursty producers can pace themselves.

## Interface
- `ADDR_W`, 4: FIFO address width; depth = 2^ADDR_W entries (16).
- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset), sampled on `clk`.
- `wr_en`  in  1  write strobe; one byte per cycle while high.
- `wr_data`  in  8  byte to enqueue, sampled with `wr_en`.
- `full`  out  1  FIFO holds 2^ADDR_W bytes.
- `empty`  out  1  FIFO holds 0 bytes.
- `count`  out  ADDR_W+1  bytes currently buffered (0..2^ADDR_W).
- `overflow`  out  1  sticky: a write was attempted while `full`.
- `tx_start`  out  1  one-cycle request to transmitter.
- `data_out`  out  8  byte for transmitter; valid while `tx_start` high, held until next issue.
- `tx_done_tick`  in  1  one-cycle pulse from transmitter at end of stop bit.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- Storage: 2^ADDR_W x 8 register array; `wr_ptr`, `rd_ptr` ADDR_W bits, wrap modulo depth naturally; `count` ADDR_W+1 bits tracks occupancy.
- Write: accepted iff `wr_en` && !`full` (registered `full`, evaluated before any same-cycle pop). Accepted write stores at `wr_ptr`, increments `wr_ptr`.
- Write while `full`: byte dropped, pointers/count unchanged, `overflow` set to 1; `overflow` clears only on reset.
- Pop: happens only in the IDLE->ISSUE transition; increments `rd_ptr`.
- Count: +1 on accepted write only, -1 on pop only, unchanged when both occur in the same cycle.
- `full` = (count == 2^ADDR_W); `empty` = (count == 0); both derived from registered `count`.
- FSM states:
  - IDLE: if !`empty`: register `tx_start`=1, `data_out`=mem[`rd_ptr`], pop, go ISSUE. Else stay.
  - ISSUE: `tx_start`=0, go WAIT (unconditional, one cycle).
  - WAIT: on `tx_done_tick`=1 go IDLE; else stay.
- `tx_done_tick` ignored in IDLE and ISSUE.
- Reset (`rst`=0): pointers, `count`=0, state IDLE, `tx_start`=0, `data_out`=8'h00, `overflow`=0, `busy`=0; `empty`=1, `full`=0. Buffered bytes discarded. Reset mid-transmission is legal; transmitter is reset by the same system reset, so no `tx_done_tick` is awaited afterward.

## Timing
- All outputs registered or decoded from registers; no combinational path from inputs to outputs.
- Write at edge N (wr_en high before N) into empty FIFO in IDLE: `count`=1 after N; `tx_start`=1 after edge N+1 with `data_out`=that byte; `count` back to 0 after N+1 unless a new write lands.
- `tx_start` high for exactly one cycle per byte; `data_out` stable from the `tx_start` cycle until the next issue.
- After `tx_done_tick` sampled at edge M: IDLE after M; next `tx_start` after edge M+1 if FIFO non-empty. Minimum byte-to-byte gap on `tx_start`: 1 cycle after done tick.
- Simultaneous write and pop in IDLE with `count`=1: new byte stored, `count` stays 1, next issue after following `tx_done_tick`.
- Wrap-around: 17th write after 16 pops lands at index 0; ordering strictly FIFO.

## Test plan
- Single byte: reset, write 8'hA5 -> `tx_start` one-cycle pulse 2 cycles after write edge, `data_out`=8'hA5, `busy`=1 until one cycle after `tx_done_tick`, `empty`=1 after pop.
- Burst order: write 8'h01..8'h05 back-to-back, model transmitter returning `tx_done_tick` 20 cycles after each `tx_start` -> five pulses with `data_out` 01,02,03,04,05 in order, no pulse before prior done tick.
- Full/overflow: with no done ticks returned after first issue, write 17 more bytes -> `count` reaches 16, `full`=1, 17th dropped, `overflow`=1 and stays 1; subsequent drain returns exactly the 16 accepted bytes.
- Wrap-around: 40 writes interleaved with done ticks, keeping count ≤ 16 -> all 40 bytes emitted in order across pointer wrap.
- Simultaneous write+pop: count=1 in IDLE, write 8'h3C on issue cycle -> `count` remains 1, 8'h3C emitted after next `tx_done_tick`.
- Reset mid-operation: count=5, state WAIT, assert `rst`=0 one cycle -> `count`=0, `empty`=1, `busy`=0, `overflow`=0, no `tx_start` afterward until new write.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers producer writes and hands them
// out one at a time with a tx_start pulse, waiting for tx_done_tick in between.
module uart_tx_fifo #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              tx_start,
    output logic [7:0]        data_out,
    input  logic              tx_done_tick,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_accept;
    logic              pop;

    // Status flags come from the registered count, so writes are judged
    // against the occupancy before any pop in the same cycle.
    assign full      = (count == (ADDR_W+1)'(DEPTH));
    assign empty     = (count == '0);
    assign busy      = (state != IDLE);
    assign wr_accept = wr_en && !full;

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    next_state = ISSUE;
                    pop        = 1'b1;
                end
            end
            ISSUE:   next_state = WAIT;
            WAIT:    if (tx_done_tick) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            tx_start <= 1'b0;
            data_out <= 8'h00;
        end else begin
            tx_start <= pop;
            if (pop) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + ADDR_W'(1);
            end
            if (wr_accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            case ({wr_accept, pop})
                2'b10:   count <= count + (ADDR_W+1)'(1);
                2'b01:   count <= count - (ADDR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (rst && wr_accept) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: cycle vector table plus scoreboarded
// sequences with a simple transmitter model returning tx_done_tick.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic       tx_start;
    logic [7:0] data_out;
    logic       tx_done_tick;
    logic       busy;

    int checks = 0;
    int fails  = 0;

    logic [7:0] expQ[$];
    logic       monOn       = 1'b0;
    logic       modelOn     = 1'b0;
    logic       outstanding = 1'b0;
    logic       prevStart   = 1'b0;
    int         doneDelay   = 20;
    int         doneTimer   = 0;
    int         issued      = 0;

    typedef struct {
        logic       we;
        logic [7:0] wd;
        logic       done;
        logic       expStart;
        logic [7:0] expData;
        logic [4:0] expCount;
        logic       expBusy;
    } vec_t;

    vec_t vecs[15];

    uart_tx_fifo #(.ADDR_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .overflow     (overflow),
        .tx_start     (tx_start),
        .data_out     (data_out),
        .tx_done_tick (tx_done_tick),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One clock: drive inputs on the falling edge, then observe just after the rising edge.
    task automatic applyStimulus(input logic we, input logic [7:0] wd, input logic done);
        logic genDone;
        @(negedge clk);
        genDone = modelOn && (doneTimer == 1);
        if (modelOn && doneTimer > 0) doneTimer--;
        wr_en        = we;
        wr_data      = wd;
        tx_done_tick = done | genDone;
        @(posedge clk);
        #1;
        if (monOn) begin
            if (tx_done_tick) outstanding = 1'b0;
            if (tx_start) begin
                checkOutput("no_early_pulse", {31'd0, outstanding}, 32'd0);
                checkOutput("single_cycle_pulse", {31'd0, prevStart}, 32'd0);
                if (expQ.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_start: got data_out %0h, expected no tx_start", data_out);
                end else begin
                    checkOutput("issue_order", {24'd0, data_out}, {24'd0, expQ.pop_front()});
                end
                outstanding = 1'b1;
                doneTimer   = doneDelay;
                issued++;
            end
            prevStart = tx_start;
        end
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((expQ.size() != 0 || outstanding) && n < budget) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            n++;
        end
        checkOutput("drain_complete", {31'd0, (expQ.size() != 0) || outstanding}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst          = 1'b0;
        wr_en        = 1'b0;
        wr_data      = 8'h00;
        tx_done_tick = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rst_count", {27'd0, count}, 32'd0);
        checkOutput("rst_empty", {31'd0, empty}, 32'd1);
        checkOutput("rst_full", {31'd0, full}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_overflow", {31'd0, overflow}, 32'd0);
        checkOutput("rst_tx_start", {31'd0, tx_start}, 32'd0);
        checkOutput("rst_data_out", {24'd0, data_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        expQ.delete();
        outstanding = 1'b0;
        prevStart   = 1'b0;
        doneTimer   = 0;
    endtask

    initial begin
        int modelCount;
        int startIssued;

        rst          = 1'b0;
        wr_en        = 1'b0;
        wr_data      = 8'h00;
        tx_done_tick = 1'b0;

        //            we    wd     done  start data   cnt   busy
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 5'd1, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 5'd0, 1'b1};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b1};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 5'd0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 5'd0, 1'b0};
        vecs[7]  = '{1'b1, 8'h11, 1'b0, 1'b0, 8'hA5, 5'd1, 1'b0};
        vecs[8]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 8'h11, 5'd1, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 5'd1, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 5'd1, 1'b1};
        vecs[11] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h11, 5'd1, 1'b0};
        vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h3C, 5'd0, 1'b1};
        vecs[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h3C, 5'd0, 1'b1};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 5'd0, 1'b0};

        repeat (3) @(posedge clk);
        applyReset();

        $display("[TB] vector table");
        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].we, vecs[i].wd, vecs[i].done);
            checkOutput($sformatf("v%0d.tx_start", i), {31'd0, tx_start}, {31'd0, vecs[i].expStart});
            checkOutput($sformatf("v%0d.data_out", i), {24'd0, data_out}, {24'd0, vecs[i].expData});
            checkOutput($sformatf("v%0d.count", i), {27'd0, count}, {27'd0, vecs[i].expCount});
            checkOutput($sformatf("v%0d.empty", i), {31'd0, empty}, {31'd0, vecs[i].expCount == 5'd0});
            checkOutput($sformatf("v%0d.busy", i), {31'd0, busy}, {31'd0, vecs[i].expBusy});
            checkOutput($sformatf("v%0d.full", i), {31'd0, full}, 32'd0);
        end

        $display("[TB] burst order");
        monOn       = 1'b1;
        modelOn     = 1'b1;
        doneDelay   = 20;
        startIssued = issued;
        for (int i = 1; i <= 5; i++) begin
            expQ.push_back(8'(i));
            applyStimulus(1'b1, 8'(i), 1'b0);
        end
        waitDrain(500);
        checkOutput("burst_issued", issued - startIssued, 32'd5);
        checkOutput("burst_overflow", {31'd0, overflow}, 32'd0);

        $display("[TB] full and overflow");
        modelOn = 1'b0;
        expQ.push_back(8'h80);
        applyStimulus(1'b1, 8'h80, 1'b0);
        repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
        modelCount = 0;
        for (int i = 0; i < 17; i++) begin
            if (modelCount < 16) begin
                expQ.push_back(8'(8'h90 + i));
                modelCount++;
            end
            applyStimulus(1'b1, 8'(8'h90 + i), 1'b0);
            if (i == 15) begin
                checkOutput("full_at_16", {31'd0, full}, 32'd1);
                checkOutput("no_overflow_yet", {31'd0, overflow}, 32'd0);
            end
        end
        checkOutput("full_count", {27'd0, count}, 32'd16);
        checkOutput("full_flag", {31'd0, full}, 32'd1);
        checkOutput("overflow_set", {31'd0, overflow}, 32'd1);
        checkOutput("busy_waiting", {31'd0, busy}, 32'd1);
        modelOn   = 1'b1;
        doneDelay = 4;
        doneTimer = 4;
        waitDrain(800);
        checkOutput("overflow_sticky", {31'd0, overflow}, 32'd1);
        checkOutput("drained_count", {27'd0, count}, 32'd0);
        checkOutput("drained_empty", {31'd0, empty}, 32'd1);

        $display("[TB] reset mid-operation");
        modelOn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            expQ.push_back(8'(8'hC0 + i));
            applyStimulus(1'b1, 8'(8'hC0 + i), 1'b0);
        end
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("pre_reset_count", {27'd0, count}, 32'd5);
        checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
        applyReset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0);
            checkOutput("quiet_after_reset", {31'd0, tx_start}, 32'd0);
        end
        modelOn   = 1'b1;
        doneDelay = 5;
        expQ.push_back(8'h5A);
        applyStimulus(1'b1, 8'h5A, 1'b0);
        waitDrain(100);

        $display("[TB] wrap-around");
        doneDelay   = 3;
        startIssued = issued;
        for (int i = 0; i < 40; i++) begin
            expQ.push_back(8'(i * 7 + 3));
            applyStimulus(1'b1, 8'(i * 7 + 3), 1'b0);
            repeat (3) applyStimulus(1'b0, 8'h00, 1'b0);
            checkOutput("count_bound", {31'd0, count > 5'd16}, 32'd0);
        end
        waitDrain(1000);
        checkOutput("wrap_issued", issued - startIssued, 32'd40);
        checkOutput("wrap_overflow", {31'd0, overflow}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
